// File: rtl/mem_arbiter_if.sv
// Bundle of the two client ports and the backend memory port of mem_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 64
`endif

interface mem_arbiter_if #(
    parameter int unsigned WIDTH = `MEMORY_WIDTH
);
    logic             c0_write_req;
    logic [31:0]      c0_write_addr;
    logic [WIDTH-1:0] c0_write_data;
    logic             c0_write_ack;
    logic             c0_read_req;
    logic [31:0]      c0_read_addr;
    logic [WIDTH-1:0] c0_read_data;
    logic             c0_read_ack;

    logic             c1_write_req;
    logic [31:0]      c1_write_addr;
    logic [WIDTH-1:0] c1_write_data;
    logic             c1_write_ack;
    logic             c1_read_req;
    logic [31:0]      c1_read_addr;
    logic [WIDTH-1:0] c1_read_data;
    logic             c1_read_ack;

    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        input  c0_write_req, c0_write_addr, c0_write_data, c0_read_req, c0_read_addr,
        input  c1_write_req, c1_write_addr, c1_write_data, c1_read_req, c1_read_addr,
        output c0_write_ack, c0_read_data, c0_read_ack,
        output c1_write_ack, c1_read_data, c1_read_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output c0_write_req, c0_write_addr, c0_write_data, c0_read_req, c0_read_addr,
        output c1_write_req, c1_write_addr, c1_write_data, c1_read_req, c1_read_addr,
        input  c0_write_ack, c0_read_data, c0_read_ack,
        input  c1_write_ack, c1_read_data, c1_read_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client, round-robin arbiter in front of a single line-wide memory port.
// One transaction at a time: IDLE (grant) -> ISSUE (wait mem_ack) -> RESP (ack).
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 64
`endif

module mem_arbiter #(
    parameter int unsigned WIDTH = `MEMORY_WIDTH,
    parameter              ALIAS = "arbiter"
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic             id_q;      // granted client
    logic             we_q;      // granted op is a write
    logic             prio_q;    // client that wins the next tie
    logic [31:0]      addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata0_q, rdata1_q;

    logic             c0_any, c1_any, grant, grant_id, grant_we;
    logic [31:0]      grant_addr;
    logic [WIDTH-1:0] grant_wdata;

    // ALIAS only tags debug output; it has no hardware meaning.
    if (ALIAS == "") begin : g_untagged
    end

    // Arbitration, write-before-read selection and next-state logic.
    always_comb begin
        c0_any      = bus.c0_write_req | bus.c0_read_req;
        c1_any      = bus.c1_write_req | bus.c1_read_req;
        grant       = 1'b0;
        state_d     = state_q;
        grant_id    = c1_any & (~c0_any | prio_q);
        grant_we    = grant_id ? bus.c1_write_req : bus.c0_write_req;
        grant_wdata = grant_id ? bus.c1_write_data : bus.c0_write_data;
        if (grant_id) begin
            grant_addr = grant_we ? bus.c1_write_addr : bus.c1_read_addr;
        end else begin
            grant_addr = grant_we ? bus.c0_write_addr : bus.c0_read_addr;
        end
        unique case (state_q)
            StIdle: begin
                if (c0_any || c1_any) begin
                    grant   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.mem_ack) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, latched transaction and per-client read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            prio_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q   <= grant_id;
                we_q   <= grant_we;
                addr_q <= grant_addr;
                prio_q <= ~grant_id;
                if (grant_we) begin
                    wdata_q <= grant_wdata;
                end
            end
            // Only the granted client's read data moves; the other holds its line.
            if (state_q == StIssue && bus.mem_ack && !we_q) begin
                if (id_q) begin
                    rdata1_q <= bus.mem_rdata;
                end else begin
                    rdata0_q <= bus.mem_rdata;
                end
            end
        end
    end

    // Backend request and single-cycle client acks decoded from the state.
    always_comb begin
        bus.mem_req      = (state_q == StIssue);
        bus.mem_we       = we_q;
        bus.mem_addr     = addr_q;
        bus.mem_wdata    = wdata_q;
        bus.c0_read_data = rdata0_q;
        bus.c1_read_data = rdata1_q;
        bus.c0_write_ack = 1'b0;
        bus.c0_read_ack  = 1'b0;
        bus.c1_write_ack = 1'b0;
        bus.c1_read_ack  = 1'b0;
        if (state_q == StResp) begin
            bus.c0_write_ack = ~id_q &  we_q;
            bus.c0_read_ack  = ~id_q & ~we_q;
            bus.c1_write_ack =  id_q &  we_q;
            bus.c1_read_ack  =  id_q & ~we_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued in grant
// order when requests are raised and retired when the arbiter acks a client.
module tb_mem_arbiter;

    localparam int W = 64;
    localparam logic [3:0] AckC0W = 4'b0001;
    localparam logic [3:0] AckC0R = 4'b0010;
    localparam logic [3:0] AckC1W = 4'b0100;
    localparam logic [3:0] AckC1R = 4'b1000;

    typedef struct {
        logic [3:0]   ack;
        logic [31:0]  addr;
        logic [W-1:0] data;
        int           lat;
        int           t0;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W)) bus ();
    mem_arbiter #(.WIDTH(W), .ALIAS("tb")) dut (.clk(clk), .reset(reset), .bus(bus));

    txn_t         sb [$];
    logic [31:0]  q0_addr [$];
    logic [31:0]  q1_addr [$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           be_lat = 1;
    int           be_cnt = 0;
    logic         be_force_ack = 1'b0;
    logic [W-1:0] rd0_m = '0;
    logic [W-1:0] rd1_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] line_of(input logic [31:0] a);
        return {(W/8){8'hA5}} ^ W'(a - 32'h100);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic [3:0] ack, input logic [31:0] addr,
                              input logic [W-1:0] data, input int lat);
        txn_t e;
        e.ack  = ack;
        e.addr = addr;
        e.data = data;
        e.lat  = lat;
        e.t0   = cyc;
        sb.push_back(e);
    endtask

    // Drop each request when its ack is seen; reads may chain a queued next address.
    task automatic wait_done(input int budget);
        int n = 0;
        while ((bus.c0_write_req | bus.c0_read_req | bus.c1_write_req | bus.c1_read_req)
               && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.c0_write_ack) bus.c0_write_req = 1'b0;
            if (bus.c1_write_ack) bus.c1_write_req = 1'b0;
            if (bus.c0_read_ack) begin
                if (q0_addr.size() > 0) bus.c0_read_addr = q0_addr.pop_front();
                else bus.c0_read_req = 1'b0;
            end
            if (bus.c1_read_ack) begin
                if (q1_addr.size() > 0) bus.c1_read_addr = q1_addr.pop_front();
                else bus.c1_read_req = 1'b0;
            end
        end
        check("requests_drained",
              bus.c0_write_req | bus.c0_read_req | bus.c1_write_req | bus.c1_read_req, 0);
        bus.c0_write_req = 1'b0;
        bus.c0_read_req  = 1'b0;
        bus.c1_write_req = 1'b0;
        bus.c1_read_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
    endtask

    // Backend model: ack after be_lat ISSUE cycles, or a forced stray ack.
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (be_force_ack) begin
            bus.mem_ack = 1'b1;
        end else if (bus.mem_req) begin
            if (be_cnt >= be_lat - 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = line_of(bus.mem_addr);
                be_cnt        = 0;
            end else begin
                be_cnt++;
            end
        end else begin
            be_cnt = 0;
        end
    end

    // Monitor: backend request contents, ack order/selection, latency, data hold.
    always @(negedge clk) begin : monitor
        logic [3:0] ackv;
        txn_t       e;
        if (reset) begin
            rd0_m = '0;
            rd1_m = '0;
        end else begin
            ackv = {bus.c1_read_ack, bus.c1_write_ack, bus.c0_read_ack, bus.c0_write_ack};
            if (bus.mem_req && sb.size() > 0) begin
                check("mem_addr", bus.mem_addr, sb[0].addr);
                check("mem_we", bus.mem_we, (sb[0].ack & (AckC0W | AckC1W)) != 0);
                if ((sb[0].ack & (AckC0W | AckC1W)) != 0)
                    check("mem_wdata", bus.mem_wdata, sb[0].data);
            end
            if (ackv != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", ackv, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_select", ackv, e.ack);
                    if (e.ack == AckC0R) rd0_m = e.data;
                    if (e.ack == AckC1R) rd1_m = e.data;
                    if (e.lat >= 0) check("ack_latency", cyc - e.t0, e.lat);
                end
            end
            check("c0_read_data", bus.c0_read_data, rd0_m);
            check("c1_read_data", bus.c1_read_data, rd1_m);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.c0_write_req = 1'b0; bus.c0_write_addr = '0; bus.c0_write_data = '0;
        bus.c0_read_req  = 1'b0; bus.c0_read_addr  = '0;
        bus.c1_write_req = 1'b0; bus.c1_write_addr = '0; bus.c1_write_data = '0;
        bus.c1_read_req  = 1'b0; bus.c1_read_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of every output.
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_c0_read_data", bus.c0_read_data, 0);
        check("rst_c1_read_data", bus.c1_read_data, 0);
        check("rst_acks", {bus.c1_read_ack, bus.c1_write_ack, bus.c0_read_ack,
                           bus.c0_write_ack}, 0);

        // c0 read of 0x100 with a 1-cycle backend.
        expect_txn(AckC0R, 32'h100, line_of(32'h100), 2);
        bus.c0_read_addr = 32'h100;
        bus.c0_read_req  = 1'b1;
        wait_done(50);
        check("c0_read_a5", bus.c0_read_data, {(W/8){8'hA5}});

        // Dirty evict to 0x200 then fill from 0x300: write served first.
        expect_txn(AckC0W, 32'h200, 64'hDEAD_BEEF_0123_4567, 2);
        expect_txn(AckC0R, 32'h300, line_of(32'h300), -1);
        bus.c0_write_addr = 32'h200;
        bus.c0_write_data = 64'hDEAD_BEEF_0123_4567;
        bus.c0_read_addr  = 32'h300;
        bus.c0_write_req  = 1'b1;
        bus.c0_read_req   = 1'b1;
        wait_done(50);

        // c1 read while c0 idle: c0's line must survive.
        expect_txn(AckC1R, 32'h400, line_of(32'h400), 2);
        bus.c1_read_addr = 32'h400;
        bus.c1_read_req  = 1'b1;
        wait_done(50);
        check("c0_line_kept", bus.c0_read_data, line_of(32'h300));

        // Both clients stream two reads each: grants alternate 0,1,0,1.
        expect_txn(AckC0R, 32'h110, line_of(32'h110), 2);
        expect_txn(AckC1R, 32'h130, line_of(32'h130), -1);
        expect_txn(AckC0R, 32'h120, line_of(32'h120), -1);
        expect_txn(AckC1R, 32'h140, line_of(32'h140), -1);
        q0_addr.push_back(32'h120);
        q1_addr.push_back(32'h140);
        bus.c0_read_addr = 32'h110;
        bus.c1_read_addr = 32'h130;
        bus.c0_read_req  = 1'b1;
        bus.c1_read_req  = 1'b1;
        wait_done(100);

        // Slow backend: request held stable for 5 cycles, one ack pulse.
        be_lat = 5;
        expect_txn(AckC1W, 32'h500, 64'h0F0F_1234_5678_9ABC, 6);
        bus.c1_write_addr = 32'h500;
        bus.c1_write_data = 64'h0F0F_1234_5678_9ABC;
        bus.c1_write_req  = 1'b1;
        wait_done(50);

        // Reset during ISSUE aborts c0's read; stray mem_ack afterwards is ignored.
        be_lat = 20;
        bus.c0_read_addr = 32'h600;
        bus.c0_read_req  = 1'b1;
        @(posedge clk);
        #1;
        check("issue_mem_req", bus.mem_req, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.c0_read_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_mem_req", bus.mem_req, 0);
        check("abort_c0_read_data", bus.c0_read_data, 0);
        be_force_ack = 1'b1;
        @(posedge clk);
        #1;
        be_force_ack = 1'b0;
        @(posedge clk);
        #1;
        check("stray_mem_req", bus.mem_req, 0);
        be_lat = 1;

        // After reset the pointer is back at c0.
        expect_txn(AckC0R, 32'h700, line_of(32'h700), 2);
        expect_txn(AckC1R, 32'h710, line_of(32'h710), -1);
        bus.c0_read_addr = 32'h700;
        bus.c1_read_addr = 32'h710;
        bus.c0_read_req  = 1'b1;
        bus.c1_read_req  = 1'b1;
        wait_done(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
